// File: rtl/wb_port_scheduler.sv
// Write-back port scheduler: arbitrates the single register-file write port between
// the in-order WB stage and a small in-order FIFO of long-latency unit results.
module wb_port_scheduler #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        WB_Valid,
    input  logic        WB_RegWre,
    input  logic [4:0]  WB_Rd,
    input  logic [1:0]  WB_Src,
    input  logic        LU_Valid,
    input  logic [4:0]  LU_Rd,
    input  logic [31:0] LU_Data,
    output logic        LU_Ready,
    output logic [1:0]  DBDataSrc,
    output logic [31:0] LUDataOut,
    output logic        RegWre,
    output logic [4:0]  WriteReg,
    output logic        Stall,
    output logic        LU_Pending
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] LIMIT    = WAIT_W'(STARVE_LIMIT);
    localparam logic [1:0]        SRC_LU   = 2'b11;

    logic [4:0]        rdMem   [DEPTH];
    logic [31:0]       dataMem [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] waitCnt;

    logic fifoEmpty;
    logic fifoFull;
    logic pipeWr;
    logic forceDrain;
    logic pop;
    logic push;
    logic bypass;

    function automatic logic [WAIT_W-1:0] satInc(input logic [WAIT_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + WAIT_W'(1);
    endfunction

    assign fifoEmpty  = (count == '0);
    assign fifoFull   = (count == FULL_CNT);
    assign pipeWr     = WB_Valid & WB_RegWre & (WB_Rd != 5'd0);
    assign forceDrain = !Reset & !fifoEmpty & (waitCnt >= LIMIT);

    // The head leaves either by force or whenever the pipeline leaves the port free.
    assign pop        = !Reset & !fifoEmpty & (forceDrain | !pipeWr);
    assign bypass     = !Reset & fifoEmpty & !pipeWr & LU_Valid & (LU_Rd != 5'd0);
    assign LU_Ready   = !Reset & (!fifoFull | pop);
    assign push       = LU_Valid & LU_Ready & (LU_Rd != 5'd0) & !bypass;
    assign LU_Pending = !Reset & !fifoEmpty;

    always_comb begin
        RegWre    = 1'b0;
        WriteReg  = 5'd0;
        DBDataSrc = 2'b00;
        LUDataOut = 32'd0;
        Stall     = 1'b0;
        if (!Reset) begin
            if (forceDrain) begin
                Stall     = 1'b1;
                RegWre    = 1'b1;
                WriteReg  = rdMem[rdPtr];
                DBDataSrc = SRC_LU;
                LUDataOut = dataMem[rdPtr];
            end else if (pipeWr) begin
                RegWre    = 1'b1;
                WriteReg  = WB_Rd;
                DBDataSrc = WB_Src;
            end else if (!fifoEmpty) begin
                RegWre    = 1'b1;
                WriteReg  = rdMem[rdPtr];
                DBDataSrc = SRC_LU;
                LUDataOut = dataMem[rdPtr];
            end else if (bypass) begin
                RegWre    = 1'b1;
                WriteReg  = LU_Rd;
                DBDataSrc = SRC_LU;
                LUDataOut = LU_Data;
            end else if (WB_Valid) begin
                DBDataSrc = WB_Src;
            end
        end
    end

    // Queue storage carries data only; validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            rdMem[wrPtr]   <= LU_Rd;
            dataMem[wrPtr] <= LU_Data;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            waitCnt <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop || fifoEmpty) waitCnt <= '0;
            else                  waitCnt <= satInc(waitCnt);
        end
    end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler: inputs change on the falling edge and the
// combinational outputs are checked 1ns later, well clear of the rising edge.
module tb_wb_port_scheduler;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        WB_Valid;
    logic        WB_RegWre;
    logic [4:0]  WB_Rd;
    logic [1:0]  WB_Src;
    logic        LU_Valid;
    logic [4:0]  LU_Rd;
    logic [31:0] LU_Data;
    logic        LU_Ready;
    logic [1:0]  DBDataSrc;
    logic [31:0] LUDataOut;
    logic        RegWre;
    logic [4:0]  WriteReg;
    logic        Stall;
    logic        LU_Pending;

    int errCnt = 0;
    int chkCnt = 0;

    wb_port_scheduler #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .Reset(Reset),
        .WB_Valid(WB_Valid), .WB_RegWre(WB_RegWre), .WB_Rd(WB_Rd), .WB_Src(WB_Src),
        .LU_Valid(LU_Valid), .LU_Rd(LU_Rd), .LU_Data(LU_Data), .LU_Ready(LU_Ready),
        .DBDataSrc(DBDataSrc), .LUDataOut(LUDataOut), .RegWre(RegWre),
        .WriteReg(WriteReg), .Stall(Stall), .LU_Pending(LU_Pending)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic wv, input logic ww, input logic [4:0] wrd,
                        input logic [1:0] wsrc, input logic lv, input logic [4:0] lrd,
                        input logic [31:0] ld);
        @(negedge CLK);
        WB_Valid = wv; WB_RegWre = ww; WB_Rd = wrd; WB_Src = wsrc;
        LU_Valid = lv; LU_Rd = lrd; LU_Data = ld;
        #1;
    endtask

    task automatic pipeOnly(input logic [4:0] wrd, input logic [1:0] wsrc);
        step(1'b1, 1'b1, wrd, wsrc, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        WB_Valid = 0; WB_RegWre = 0; WB_Rd = 0; WB_Src = 0;
        LU_Valid = 0; LU_Rd = 0; LU_Data = 0;

        // Reset held 3 cycles, with a long result offered to check output gating
        step(1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 5'd4, 32'h1234);
        chk("rst_regwre", 32'(RegWre), 32'd0);
        chk("rst_ready", 32'(LU_Ready), 32'd0);
        chk("rst_ludata", LUDataOut, 32'd0);
        idle();
        idle();
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        chk("idle_regwre", 32'(RegWre), 32'd0);
        chk("idle_src", 32'(DBDataSrc), 32'd0);
        chk("idle_stall", 32'(Stall), 32'd0);
        chk("idle_ready", 32'(LU_Ready), 32'd1);
        chk("idle_pending", 32'(LU_Pending), 32'd0);

        // Pipeline pass-through
        for (int s = 0; s < 3; s++) begin
            pipeOnly(5'd5, 2'(s));
            chk("pass_regwre", 32'(RegWre), 32'd1);
            chk("pass_wreg", 32'(WriteReg), 32'd5);
            chk("pass_src", 32'(DBDataSrc), 32'(s));
        end
        pipeOnly(5'd0, 2'b01);
        chk("rd0_regwre", 32'(RegWre), 32'd0);
        chk("rd0_src", 32'(DBDataSrc), 32'd1);

        // Bypass
        step(1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 5'd9, 32'hDEAD_BEEF);
        chk("byp_regwre", 32'(RegWre), 32'd1);
        chk("byp_src", 32'(DBDataSrc), 32'd3);
        chk("byp_wreg", 32'(WriteReg), 32'd9);
        chk("byp_data", LUDataOut, 32'hDEAD_BEEF);
        idle();
        chk("byp_pending", 32'(LU_Pending), 32'd0);
        chk("byp_after_regwre", 32'(RegWre), 32'd0);

        // Queue then drain
        step(1'b1, 1'b1, 5'd3, 2'b00, 1'b1, 5'd7, 32'h11);
        chk("q1_wreg", 32'(WriteReg), 32'd3);
        chk("q1_ready", 32'(LU_Ready), 32'd1);
        step(1'b1, 1'b1, 5'd3, 2'b00, 1'b1, 5'd8, 32'h22);
        chk("q2_wreg", 32'(WriteReg), 32'd3);
        chk("q2_pending", 32'(LU_Pending), 32'd1);
        idle();
        chk("d1_pending", 32'(LU_Pending), 32'd1);
        chk("d1_regwre", 32'(RegWre), 32'd1);
        chk("d1_wreg", 32'(WriteReg), 32'd7);
        chk("d1_src", 32'(DBDataSrc), 32'd3);
        chk("d1_data", LUDataOut, 32'h11);
        idle();
        chk("d2_wreg", 32'(WriteReg), 32'd8);
        chk("d2_data", LUDataOut, 32'h22);
        idle();
        chk("d3_pending", 32'(LU_Pending), 32'd0);
        chk("d3_regwre", 32'(RegWre), 32'd0);

        // Full FIFO under continuous pipe writes
        step(1'b1, 1'b1, 5'd3, 2'b00, 1'b1, 5'd10, 32'hA);
        chk("f1_ready", 32'(LU_Ready), 32'd1);
        step(1'b1, 1'b1, 5'd3, 2'b00, 1'b1, 5'd11, 32'hB);
        chk("f2_ready", 32'(LU_Ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 5'd3, 2'b00, 1'b1, 5'd12, 32'hC);
            chk("full_ready", 32'(LU_Ready), 32'd0);
            chk("full_wreg", 32'(WriteReg), 32'd3);
        end
        step(1'b1, 1'b1, 5'd3, 2'b00, 1'b1, 5'd12, 32'hC);
        chk("fpop_stall", 32'(Stall), 32'd1);
        chk("fpop_ready", 32'(LU_Ready), 32'd1);
        chk("fpop_wreg", 32'(WriteReg), 32'd10);
        chk("fpop_data", LUDataOut, 32'hA);
        idle();
        chk("fd1_wreg", 32'(WriteReg), 32'd11);
        chk("fd1_data", LUDataOut, 32'hB);
        idle();
        chk("fd2_wreg", 32'(WriteReg), 32'd12);
        chk("fd2_data", LUDataOut, 32'hC);
        idle();
        chk("fd3_pending", 32'(LU_Pending), 32'd0);

        // Starvation: one queued result behind continuous pipe writes
        step(1'b1, 1'b1, 5'd3, 2'b01, 1'b1, 5'd20, 32'h55);
        chk("s0_wreg", 32'(WriteReg), 32'd3);
        for (int i = 0; i < 4; i++) begin
            pipeOnly(5'd3, 2'b01);
            chk("swait_stall", 32'(Stall), 32'd0);
            chk("swait_wreg", 32'(WriteReg), 32'd3);
            chk("swait_pending", 32'(LU_Pending), 32'd1);
        end
        pipeOnly(5'd3, 2'b01);
        chk("sforce_stall", 32'(Stall), 32'd1);
        chk("sforce_regwre", 32'(RegWre), 32'd1);
        chk("sforce_wreg", 32'(WriteReg), 32'd20);
        chk("sforce_src", 32'(DBDataSrc), 32'd3);
        chk("sforce_data", LUDataOut, 32'h55);
        pipeOnly(5'd3, 2'b01);
        chk("safter_stall", 32'(Stall), 32'd0);
        chk("safter_wreg", 32'(WriteReg), 32'd3);
        chk("safter_src", 32'(DBDataSrc), 32'd1);
        chk("safter_pending", 32'(LU_Pending), 32'd0);

        // Reset on the cycle a forced drain would occur
        step(1'b1, 1'b1, 5'd3, 2'b00, 1'b1, 5'd21, 32'h66);
        step(1'b1, 1'b1, 5'd3, 2'b00, 1'b1, 5'd22, 32'h77);
        for (int i = 0; i < 3; i++) pipeOnly(5'd3, 2'b00);
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        chk("rmid_stall", 32'(Stall), 32'd0);
        chk("rmid_pending", 32'(LU_Pending), 32'd0);
        chk("rmid_regwre", 32'(RegWre), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        idle();
        chk("rpost_pending", 32'(LU_Pending), 32'd0);
        chk("rpost_regwre", 32'(RegWre), 32'd0);
        chk("rpost_ready", 32'(LU_Ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Owns the single register-file write port and drives the select of the write-back mux.
- Merges two sources of register writes:
  - the in-order pipeline WB stage (ALU result, memory data or PC+4);
  - results from a long-latency unit (multiplier/divider), which arrive out of band.
- Long-unit results queue in a small FIFO and drain into free WB slots. If a result starves, the block stalls the pipeline for one slot to force it out.
- The write-back mux gains a fourth input, LUDataOut, selected by code 2'b11.

Parameters:
- DEPTH, 2, long-unit result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, cycles the FIFO head may wait before a forced drain (>=1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- WB_Valid  input  1  pipeline WB stage holds a valid instruction.
- WB_RegWre  input  1  that instruction writes a register.
- WB_Rd  input  5  its destination register.
- WB_Src  input  2  its data source: 00 ALU, 01 Mem, 10 PC+4 (11 illegal from pipeline).
- LU_Valid  input  1  long unit presents a result.
- LU_Rd  input  5  destination of that result.
- LU_Data  input  32  result data.
- LU_Ready  output  1  scheduler accepts the result this cycle.
- DBDataSrc  output  2  write-back mux select (11 = LUDataOut).
- LUDataOut  output  32  long-unit data for mux input 11.
- RegWre  output  1  register-file write enable.
- WriteReg  output  5  register-file write address.
- Stall  output  1  pipeline must hold its WB stage this cycle.
- LU_Pending  output  1  FIFO non-empty (consumed by the hazard unit).

Behaviour:
- All outputs are combinational from current state and inputs; FIFO and counter are the only state.
- While Reset is high:
  - FIFO empty, wait counter 0.
  - LU_Ready=0, RegWre=0, DBDataSrc=00, WriteReg=0, LUDataOut=0, Stall=0, LU_Pending=0.
  - A reset mid-drain discards all queued results.
- Signal definitions:
  - pipe_wr = WB_Valid & WB_RegWre & (WB_Rd!=0).
  - force = FIFO non-empty & (wait counter >= STARVE_LIMIT).
- Priority each cycle; exactly one action is taken:
  1. force:
     - Stall=1; head written: RegWre=1, WriteReg=head rd, DBDataSrc=11, LUDataOut=head data; pop.
     - Pipeline write suppressed; the pipeline re-presents it next cycle.
  2. pipe_wr:
     - RegWre=1, WriteReg=WB_Rd, DBDataSrc=WB_Src; zero latency.
  3. FIFO non-empty:
     - head written with DBDataSrc=11; pop.
  4. FIFO empty & LU_Valid & LU_Rd!=0 (bypass):
     - LU_Data written directly, DBDataSrc=11, WriteReg=LU_Rd; not enqueued.
  5. Otherwise:
     - RegWre=0; DBDataSrc holds WB_Src if WB_Valid, else 00; WriteReg=0.
- Enqueue:
  - LU_Ready = !full, or full and a pop happens this cycle (pop-and-push when full is allowed).
  - An accepted LU result with LU_Rd!=0 is enqueued unless it was bypassed (case 4).
  - LU_Rd=0 results are accepted and dropped.
- Ordering:
  - FIFO is strictly in order; pointers wrap modulo DEPTH.
  - Simultaneous push and pop on a non-empty FIFO keeps occupancy unchanged.
- Wait counter:
  - Cleared on every pop and whenever the FIFO is empty.
  - Otherwise increments each cycle the head is not written, saturating at STARVE_LIMIT.
- LU_Pending = FIFO non-empty, using registered occupancy.
- Register-hazard ordering between queued long results and later pipeline writes to the same rd is guaranteed upstream by the hazard unit, which uses LU_Pending.

Test Plan:
- Reset then idle:
  - Hold Reset 3 cycles, release; all inputs 0.
  - Required: RegWre=0, DBDataSrc=00, Stall=0, LU_Ready=1 after release.
- Pipeline pass-through:
  - WB_Valid=1, WB_RegWre=1, WB_Rd=5, WB_Src cycled 00/01/10 on consecutive cycles.
  - Required: same cycle RegWre=1, WriteReg=5, DBDataSrc equals WB_Src; WB_Rd=0 gives RegWre=0.
- Bypass:
  - FIFO empty, no pipe write, LU_Valid=1, LU_Rd=9, LU_Data=32'hDEAD_BEEF.
  - Required: same cycle DBDataSrc=11, WriteReg=9, LUDataOut=32'hDEAD_BEEF; LU_Pending stays 0.
- Queue then drain:
  - Pipe writes rd 3 for 2 cycles while LU results (rd 7, 8'h11) and (rd 8, 8'h22) arrive.
  - Required: both enqueued, LU_Pending=1.
  - Pipe idle next: rd 7 written, then rd 8, in order, DBDataSrc=11.
- Full FIFO:
  - DEPTH=2 filled under continuous pipe writes; third LU_Valid offered.
  - Required: LU_Ready=0 until a pop cycle, then LU_Ready=1 with occupancy staying 2.
- Starvation:
  - Continuous pipe writes with one queued result.
  - Required: after 4 waiting cycles, Stall=1 for exactly one cycle, head written with DBDataSrc=11, pipeline write suppressed that cycle.
  - Assert Reset mid-sequence: FIFO cleared, Stall=0 immediately.
